// File: rtl/game_sprite_multi_pkg.sv
// Shared types and constants for the multi-sprite engine.
// The RGB output width is a project-wide macro; 3 bits unless the build overrides it.
`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 3
`endif

package game_sprite_multi_pkg;

  localparam int unsigned PIX_W = 4;
  localparam logic [PIX_W-1:0] PIX_TRANSPARENT = 4'h0;

  typedef enum logic [1:0] {
    MODE_FREE   = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_e;

  // Code 3 is reserved and behaves as free motion.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_WRAP;
      2'd2:    return MODE_BOUNCE;
      default: return MODE_FREE;
    endcase
  endfunction

endpackage

// File: rtl/game_sprite_multi_motion.sv
// One sprite's position/velocity/mode registers with write muxing and edge handling.
module game_sprite_multi_motion
  import game_sprite_multi_pkg::*;
#(
  parameter int unsigned W_X      = 10,
  parameter int unsigned W_Y      = 9,
  parameter int unsigned DX_WIDTH = 2,
  parameter int unsigned DY_WIDTH = 2,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned SPR_W    = 8,
  parameter int unsigned SPR_H    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                strobe,
  input  logic                enable,
  input  logic                write_xy,
  input  logic [W_X-1:0]      write_x,
  input  logic [W_Y-1:0]      write_y,
  input  logic                write_dxy,
  input  logic [DX_WIDTH-1:0] write_dx,
  input  logic [DY_WIDTH-1:0] write_dy,
  input  logic [1:0]          write_mode,
  output logic [W_X-1:0]      x,
  output logic [W_Y-1:0]      y
);

  localparam int unsigned XE = W_X + 2;
  localparam int unsigned YE = W_Y + 2;
  localparam logic signed [XE-1:0] X_LIM = XE'(SCREEN_W);
  localparam logic signed [XE-1:0] X_MAX = XE'(SCREEN_W - SPR_W);
  localparam logic signed [YE-1:0] Y_LIM = YE'(SCREEN_H);
  localparam logic signed [YE-1:0] Y_MAX = YE'(SCREEN_H - SPR_H);

  logic [W_X-1:0]      r_x;
  logic [W_Y-1:0]      r_y;
  logic [DX_WIDTH-1:0] r_dx;
  logic [DY_WIDTH-1:0] r_dy;
  mode_e               r_mode;

  logic signed [XE-1:0] w_sum_x;
  logic signed [YE-1:0] w_sum_y;
  logic [W_X-1:0]       w_nx;
  logic [W_Y-1:0]       w_ny;
  logic [DX_WIDTH-1:0]  w_ndx;
  logic [DY_WIDTH-1:0]  w_ndy;
  logic                 w_upd;

  assign x = r_x;
  assign y = r_y;
  assign w_upd = strobe && enable && !write_xy && !write_dxy;

  // Next position per axis; sums are widened by two bits so the sign and overflow are visible.
  always_comb begin
    w_sum_x = $signed({2'b00, r_x}) + $signed({{(XE-DX_WIDTH){r_dx[DX_WIDTH-1]}}, r_dx});
    w_sum_y = $signed({2'b00, r_y}) + $signed({{(YE-DY_WIDTH){r_dy[DY_WIDTH-1]}}, r_dy});
    w_nx  = w_sum_x[W_X-1:0];
    w_ny  = w_sum_y[W_Y-1:0];
    w_ndx = r_dx;
    w_ndy = r_dy;
    case (r_mode)
      MODE_WRAP: begin
        if (w_sum_x[XE-1])          w_nx = W_X'(w_sum_x + X_LIM);
        else if (w_sum_x >= X_LIM)  w_nx = W_X'(w_sum_x - X_LIM);
        if (w_sum_y[YE-1])          w_ny = W_Y'(w_sum_y + Y_LIM);
        else if (w_sum_y >= Y_LIM)  w_ny = W_Y'(w_sum_y - Y_LIM);
      end
      MODE_BOUNCE: begin
        if (w_sum_x[XE-1]) begin
          w_nx  = '0;
          w_ndx = -r_dx;
        end else if (w_sum_x > X_MAX) begin
          w_nx  = W_X'(X_MAX);
          w_ndx = -r_dx;
        end
        if (w_sum_y[YE-1]) begin
          w_ny  = '0;
          w_ndy = -r_dy;
        end else if (w_sum_y > Y_MAX) begin
          w_ny  = W_Y'(Y_MAX);
          w_ndy = -r_dy;
        end
      end
      default: ;
    endcase
  end

  // Host writes suppress this sprite's strobe update in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_dx   <= '0;
      r_dy   <= '0;
      r_mode <= MODE_FREE;
    end else begin
      if (write_xy) begin
        r_x <= write_x;
        r_y <= write_y;
      end
      if (write_dxy) begin
        r_dx   <= write_dx;
        r_dy   <= write_dy;
        r_mode <= decode_mode(write_mode);
      end
      if (w_upd) begin
        r_x  <= w_nx;
        r_y  <= w_ny;
        r_dx <= w_ndx;
        r_dy <= w_ndy;
      end
    end
  end

endmodule

// File: rtl/game_sprite_multi.sv
// Multi-sprite engine: per-sprite motion, writable bitmaps, priority mux to one
// registered RGB stream, and sticky collision flags.
module game_sprite_multi
  import game_sprite_multi_pkg::*;
#(
  parameter int unsigned NUM_SPRITES   = 4,
  parameter int unsigned SPRITE_WIDTH  = 8,
  parameter int unsigned SPRITE_HEIGHT = 8,
  parameter int unsigned DX_WIDTH      = 2,
  parameter int unsigned DY_WIDTH      = 2,
  parameter int unsigned screen_width  = 640,
  parameter int unsigned screen_height = 480,
  parameter int unsigned w_x           = $clog2(screen_width),
  parameter int unsigned w_y           = $clog2(screen_height),
  parameter int unsigned strobe_to_update_xy_counter_width = 20,
  parameter int unsigned SEL_W = (NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1),
  parameter int unsigned ROW_W = (SPRITE_HEIGHT > 1 ? $clog2(SPRITE_HEIGHT) : 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [w_x-1:0]                pixel_x,
  input  logic [w_y-1:0]                pixel_y,
  input  logic [SEL_W-1:0]              wr_sel,
  input  logic                          write_xy,
  input  logic [w_x-1:0]                write_x,
  input  logic [w_y-1:0]                write_y,
  input  logic                          write_dxy,
  input  logic [DX_WIDTH-1:0]           write_dx,
  input  logic [DY_WIDTH-1:0]           write_dy,
  input  logic [1:0]                    write_mode,
  input  logic [NUM_SPRITES-1:0]        enable_update,
  input  logic                          bmp_we,
  input  logic [ROW_W-1:0]              bmp_row,
  input  logic [4*SPRITE_WIDTH-1:0]     bmp_data,
  input  logic                          collision_clear,
  output logic [NUM_SPRITES*w_x-1:0]    sprite_x,
  output logic [NUM_SPRITES*w_y-1:0]    sprite_y,
  output logic [NUM_SPRITES-1:0]        collision,
  output logic                          rgb_en,
  output logic [`GAME_RGB_WIDTH-1:0]    rgb,
  output logic [SEL_W-1:0]              hit_id
);

  localparam int unsigned ROW_BITS = PIX_W * SPRITE_WIDTH;
  localparam int unsigned RGB_W    = `GAME_RGB_WIDTH;
  localparam int unsigned CNT_W    = strobe_to_update_xy_counter_width;

  logic [CNT_W-1:0]    r_strobe_cnt;
  logic                w_strobe;
  logic [ROW_BITS-1:0] r_bmp [NUM_SPRITES][SPRITE_HEIGHT];

  logic [w_x-1:0]         w_pos_x [NUM_SPRITES];
  logic [w_y-1:0]         w_pos_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_sel_hit;
  logic [w_x-1:0]         w_rel_x [NUM_SPRITES];
  logic [w_y-1:0]         w_rel_y [NUM_SPRITES];
  logic [PIX_W-1:0]       w_code  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_hit;
  logic                   w_on_screen;
  logic                   w_any;
  logic [RGB_W-1:0]       w_rgb;
  logic [SEL_W-1:0]       w_id;
  logic                   w_multi;

  logic                   r_rgb_en;
  logic [RGB_W-1:0]       r_rgb;
  logic [SEL_W-1:0]       r_hit_id;
  logic [NUM_SPRITES-1:0] r_coll;

  assign w_strobe  = &r_strobe_cnt;
  assign rgb_en    = r_rgb_en;
  assign rgb       = r_rgb;
  assign hit_id    = r_hit_id;
  assign collision = r_coll;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_strobe_cnt <= '0;
    else      r_strobe_cnt <= r_strobe_cnt + CNT_W'(1);
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    assign w_sel_hit[g] = (wr_sel == SEL_W'(g));

    game_sprite_multi_motion #(
      .W_X(w_x), .W_Y(w_y), .DX_WIDTH(DX_WIDTH), .DY_WIDTH(DY_WIDTH),
      .SCREEN_W(screen_width), .SCREEN_H(screen_height),
      .SPR_W(SPRITE_WIDTH), .SPR_H(SPRITE_HEIGHT)
    ) u_motion (
      .clk        (clk),
      .rst        (rst),
      .strobe     (w_strobe),
      .enable     (enable_update[g]),
      .write_xy   (write_xy && w_sel_hit[g]),
      .write_x    (write_x),
      .write_y    (write_y),
      .write_dxy  (write_dxy && w_sel_hit[g]),
      .write_dx   (write_dx),
      .write_dy   (write_dy),
      .write_mode (write_mode),
      .x          (w_pos_x[g]),
      .y          (w_pos_y[g])
    );

    assign sprite_x[g*w_x +: w_x] = w_pos_x[g];
    assign sprite_y[g*w_y +: w_y] = w_pos_y[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        for (int r = 0; r < SPRITE_HEIGHT; r++)
          r_bmp[i][r] <= '0;
    end else if (bmp_we) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        for (int r = 0; r < SPRITE_HEIGHT; r++)
          if (w_sel_hit[i] && bmp_row == ROW_W'(r)) r_bmp[i][r] <= bmp_data;
    end
  end

  // Relative offsets wrap modulo the coordinate width so sprites straddling 0 still draw.
  always_comb begin
    w_on_screen = (32'(pixel_x) < screen_width) && (32'(pixel_y) < screen_height);
    w_hit = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_rel_x[i] = pixel_x - w_pos_x[i];
      w_rel_y[i] = pixel_y - w_pos_y[i];
      w_code[i]  = PIX_TRANSPARENT;
      if (32'(w_rel_x[i]) < SPRITE_WIDTH && 32'(w_rel_y[i]) < SPRITE_HEIGHT)
        w_code[i] = r_bmp[i][w_rel_y[i][ROW_W-1:0]]
                         [PIX_W*(SPRITE_WIDTH-1-32'(w_rel_x[i])) +: PIX_W];
      w_hit[i] = w_on_screen && (w_code[i] != PIX_TRANSPARENT);
    end
  end

  // Scan from the top index down so the lowest-index hitting sprite is left standing.
  always_comb begin
    w_any = 1'b0;
    w_rgb = '0;
    w_id  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any = 1'b1;
        w_rgb = RGB_W'(w_code[i]);
        w_id  = SEL_W'(i);
      end
    end
    w_multi = ($countones(w_hit) > 1);
  end

  // A new overlap wins over a concurrent clear for the bits it sets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb_en <= 1'b0;
      r_rgb    <= '0;
      r_hit_id <= '0;
      r_coll   <= '0;
    end else begin
      r_rgb_en <= w_any;
      r_rgb    <= w_rgb;
      r_hit_id <= w_id;
      r_coll   <= (collision_clear ? '0 : r_coll) | (w_multi ? w_hit : '0);
    end
  end

endmodule

// File: tb/tb_game_sprite_multi.sv
// Self-checking bench for game_sprite_multi: motion modes, rendering, priority,
// collisions, write precedence and reset.
module tb_game_sprite_multi;

  localparam int W_X = 10;
  localparam int W_Y = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [8:0]  pixel_y = '0;
  logic [1:0]  wr_sel = '0;
  logic        write_xy = 1'b0;
  logic [9:0]  write_x = '0;
  logic [8:0]  write_y = '0;
  logic        write_dxy = 1'b0;
  logic [1:0]  write_dx = '0;
  logic [1:0]  write_dy = '0;
  logic [1:0]  write_mode = '0;
  logic [3:0]  enable_update = '0;
  logic        bmp_we = 1'b0;
  logic [2:0]  bmp_row = '0;
  logic [31:0] bmp_data = '0;
  logic        collision_clear = 1'b0;
  logic [39:0] sprite_x;
  logic [35:0] sprite_y;
  logic [3:0]  collision;
  logic        rgb_en;
  logic [2:0]  rgb;
  logic [1:0]  hit_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         px;
    int         py;
    logic       clr;
    logic       en;
    logic [2:0] rgb;
    logic [1:0] id;
    logic [3:0] coll;
  } step_t;

  step_t sb[$];
  logic [3:0] tb_cnt;

  always #5 clk = ~clk;

  // Reference copy of the 4-bit motion strobe counter.
  always @(posedge clk or negedge rst)
    if (!rst) tb_cnt <= '0;
    else      tb_cnt <= tb_cnt + 4'd1;

  game_sprite_multi #(.strobe_to_update_xy_counter_width(4)) dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .wr_sel(wr_sel),
    .write_xy(write_xy), .write_x(write_x), .write_y(write_y),
    .write_dxy(write_dxy), .write_dx(write_dx), .write_dy(write_dy), .write_mode(write_mode),
    .enable_update(enable_update), .bmp_we(bmp_we), .bmp_row(bmp_row), .bmp_data(bmp_data),
    .collision_clear(collision_clear), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .collision(collision), .rgb_en(rgb_en), .rgb(rgb), .hit_id(hit_id)
  );

  function automatic logic [9:0] sx(input int i);
    return sprite_x[i*W_X +: W_X];
  endfunction

  function automatic logic [8:0] sy(input int i);
    return sprite_y[i*W_Y +: W_Y];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_xy(input int sel, input int x, input int y);
    wr_sel = 2'(sel); write_x = 10'(x); write_y = 9'(y); write_xy = 1'b1;
    tick();
    write_xy = 1'b0;
  endtask

  task automatic wr_dxy(input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] mode, input int sel);
    wr_sel = 2'(sel); write_dx = dx; write_dy = dy; write_mode = mode; write_dxy = 1'b1;
    tick();
    write_dxy = 1'b0;
  endtask

  task automatic wr_bmp(input int sel, input int row, input logic [31:0] data);
    wr_sel = 2'(sel); bmp_row = 3'(row); bmp_data = data; bmp_we = 1'b1;
    tick();
    bmp_we = 1'b0;
  endtask

  // Advance until the next strobe edge has just been taken.
  task automatic wait_strobe();
    int n = 0;
    while (tb_cnt != 4'hF && n < 40) begin
      tick();
      n++;
    end
    if (tb_cnt != 4'hF) begin
      checks++; errors++;
      $display("FAIL strobe_wait: counter stuck at %0d, required 15", tb_cnt);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    checks++; if (sprite_x !== '0) begin errors++; $display("FAIL reset_x: got %h required 0", sprite_x); end
    checks++; if (sprite_y !== '0) begin errors++; $display("FAIL reset_y: got %h required 0", sprite_y); end
    checks++; if (rgb_en !== 1'b0) begin errors++; $display("FAIL reset_rgb_en: got %b required 0", rgb_en); end
    checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL reset_rgb: got %b required 0", rgb); end
    checks++; if (hit_id !== 2'd0) begin errors++; $display("FAIL reset_hit_id: got %0d required 0", hit_id); end
    checks++; if (collision !== 4'd0) begin errors++; $display("FAIL reset_collision: got %b required 0", collision); end
  endtask

  task automatic test_bounce();
    int exp_x[6] = '{629, 630, 631, 632, 632, 631};
    wr_xy(0, 628, 0);
    wr_dxy(2'b01, 2'b00, 2'd2, 0);
    enable_update = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      wait_strobe();
      checks++;
      if (sx(0) !== 10'(exp_x[k])) begin
        errors++; $display("FAIL bounce_x[%0d]: got %0d required %0d", k, sx(0), exp_x[k]);
      end
    end
    checks++; if (sy(0) !== 9'd0) begin errors++; $display("FAIL bounce_y: got %0d required 0", sy(0)); end
    enable_update = 4'b0000;
  endtask

  task automatic test_wrap();
    wr_xy(1, 0, 479);
    wr_dxy(2'b11, 2'b01, 2'd1, 1);
    enable_update = 4'b0010;
    wait_strobe();
    checks++; if (sx(1) !== 10'd639) begin errors++; $display("FAIL wrap_x_neg: got %0d required 639", sx(1)); end
    checks++; if (sy(1) !== 9'd0) begin errors++; $display("FAIL wrap_y_over: got %0d required 0", sy(1)); end
    wait_strobe();
    checks++; if (sx(1) !== 10'd638) begin errors++; $display("FAIL wrap_x_2: got %0d required 638", sx(1)); end
    checks++; if (sy(1) !== 9'd1) begin errors++; $display("FAIL wrap_y_2: got %0d required 1", sy(1)); end
    enable_update = 4'b0000;
  endtask

  task automatic test_render();
    step_t st[$];
    step_t e;
    wr_xy(2, 100, 50);
    wr_bmp(2, 0, 32'h000cc000);
    wr_bmp(2, 7, 32'hffffffff);
    wr_xy(3, 636, 470);
    wr_bmp(3, 7, 32'hffffffff);
    wr_xy(1, 1020, 300);
    wr_bmp(1, 0, 32'h0000000a);
    st.push_back('{103, 50, 1'b0, 1'b1, 3'd4, 2'd2, 4'd0});
    st.push_back('{100, 50, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0});
    st.push_back('{104, 50, 1'b0, 1'b1, 3'd4, 2'd2, 4'd0});
    st.push_back('{105, 50, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0});
    st.push_back('{103, 51, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0});
    st.push_back('{103, 49, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0});
    st.push_back('{107, 57, 1'b0, 1'b1, 3'd7, 2'd2, 4'd0});
    st.push_back('{108, 57, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0});
    st.push_back('{639, 477, 1'b0, 1'b1, 3'd7, 2'd3, 4'd0});
    st.push_back('{640, 477, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0});
    st.push_back('{3, 300, 1'b0, 1'b1, 3'd2, 2'd1, 4'd0});
    st.push_back('{4, 300, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0});
    foreach (st[k]) begin
      pixel_x = 10'(st[k].px); pixel_y = 9'(st[k].py); collision_clear = st[k].clr;
      sb.push_back(st[k]);
      tick();
      collision_clear = 1'b0;
      e = sb.pop_front();
      checks++;
      if (rgb_en !== e.en || rgb !== e.rgb || hit_id !== e.id || collision !== e.coll) begin
        errors++;
        $display("FAIL render (%0d,%0d): got en=%b rgb=%b id=%0d coll=%b required en=%b rgb=%b id=%0d coll=%b",
                 e.px, e.py, rgb_en, rgb, hit_id, collision, e.en, e.rgb, e.id, e.coll);
      end
    end
  endtask

  task automatic test_priority_collision();
    step_t st[$];
    step_t e;
    wr_xy(0, 10, 10);
    wr_bmp(0, 0, 32'hf0000000);
    wr_xy(3, 10, 10);
    wr_bmp(3, 0, 32'h99000000);
    st.push_back('{10, 10, 1'b0, 1'b1, 3'd7, 2'd0, 4'b1001});
    st.push_back('{50, 50, 1'b0, 1'b0, 3'd0, 2'd0, 4'b1001});
    st.push_back('{50, 50, 1'b1, 1'b0, 3'd0, 2'd0, 4'b0000});
    st.push_back('{11, 10, 1'b0, 1'b1, 3'd1, 2'd3, 4'b0000});
    st.push_back('{10, 10, 1'b1, 1'b1, 3'd7, 2'd0, 4'b1001});
    st.push_back('{50, 50, 1'b0, 1'b0, 3'd0, 2'd0, 4'b1001});
    foreach (st[k]) begin
      pixel_x = 10'(st[k].px); pixel_y = 9'(st[k].py); collision_clear = st[k].clr;
      sb.push_back(st[k]);
      tick();
      collision_clear = 1'b0;
      e = sb.pop_front();
      checks++;
      if (rgb_en !== e.en || rgb !== e.rgb || hit_id !== e.id || collision !== e.coll) begin
        errors++;
        $display("FAIL priority[%0d] (%0d,%0d) clr=%b: got en=%b rgb=%b id=%0d coll=%b required en=%b rgb=%b id=%0d coll=%b",
                 k, e.px, e.py, e.clr, rgb_en, rgb, hit_id, collision, e.en, e.rgb, e.id, e.coll);
      end
    end
  endtask

  task automatic test_back_to_back_write();
    int exp_x[4] = '{101, 50, 301, 401};
    int exp_y[4] = '{101, 60, 301, 401};
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      wr_xy(i, 100 * (i + 1), 100 * (i + 1));
      wr_dxy(2'b01, 2'b01, 2'd0, i);
    end
    enable_update = 4'b1111;
    while (tb_cnt != 4'hF && n < 40) begin
      tick();
      n++;
    end
    wr_sel = 2'd1; write_x = 10'd50; write_y = 9'd60; write_xy = 1'b1;
    bmp_row = 3'd0; bmp_data = 32'h50000000; bmp_we = 1'b1;
    tick();
    write_xy = 1'b0; bmp_we = 1'b0; enable_update = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sx(i) !== 10'(exp_x[i]) || sy(i) !== 9'(exp_y[i])) begin
        errors++;
        $display("FAIL precedence sprite%0d: got (%0d,%0d) required (%0d,%0d)", i, sx(i), sy(i), exp_x[i], exp_y[i]);
      end
    end
    pixel_x = 10'd50; pixel_y = 9'd60;
    tick();
    checks++;
    if (rgb_en !== 1'b1 || rgb !== 3'b101 || hit_id !== 2'd1) begin
      errors++;
      $display("FAIL same_cycle_bmp: got en=%b rgb=%b id=%0d required en=1 rgb=101 id=1", rgb_en, rgb, hit_id);
    end
  endtask

  task automatic test_midrun_reset();
    #3 rst = 1'b0;
    #1;
    checks++; if (sprite_x !== '0 || sprite_y !== '0) begin
      errors++; $display("FAIL midreset_pos: got x=%h y=%h required 0", sprite_x, sprite_y);
    end
    checks++; if (rgb_en !== 1'b0) begin errors++; $display("FAIL midreset_rgb_en: got %b required 0", rgb_en); end
    checks++; if (collision !== 4'd0) begin errors++; $display("FAIL midreset_collision: got %b required 0", collision); end
    tick();
    rst = 1'b1;
    pixel_x = 10'd0; pixel_y = 9'd0;
    tick();
    checks++; if (rgb_en !== 1'b0 || hit_id !== 2'd0) begin
      errors++; $display("FAIL midreset_bitmap: got en=%b id=%0d required en=0 id=0", rgb_en, hit_id);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_wrap();
    test_render();
    test_priority_collision();
    test_back_to_back_write();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sprite_multi.md
Name: game_sprite_multi

Overview:
Parametrised multi-sprite engine: NUM_SPRITES independent sprites, each with its own position, velocity, edge mode and run-time-writable bitmap. A shared strobe counter sets motion speed. Each pixel goes through a priority mux into one registered RGB stream. Overlapping opaque sprite pixels raise sticky per-sprite collision flags. It sits between game logic and the VGA mixer and generalises the single-sprite control+display pair.

Parameters:
NUM_SPRITES, 4, number of sprites (1..16)
SPRITE_WIDTH, 8, bitmap width in pixels
SPRITE_HEIGHT, 8, bitmap height in pixels
DX_WIDTH, 2, signed two's-complement X velocity width
DY_WIDTH, 2, signed two's-complement Y velocity width
screen_width, 640, visible width
screen_height, 480, visible height
w_x, $clog2(screen_width), X coordinate width
w_y, $clog2(screen_height), Y coordinate width
strobe_to_update_xy_counter_width, 20, motion strobe counter width
SEL_W, (NUM_SPRITES>1 ? $clog2(NUM_SPRITES) : 1), sprite select width
ROW_W, (SPRITE_HEIGHT>1 ? $clog2(SPRITE_HEIGHT) : 1), bitmap row address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
pixel_x  in  w_x  current beam X
pixel_y  in  w_y  current beam Y
wr_sel  in  SEL_W  sprite targeted by all write ports
write_xy  in  1  load write_x/write_y into wr_sel
write_x  in  w_x  new X
write_y  in  w_y  new Y
write_dxy  in  1  load write_dx/write_dy/write_mode into wr_sel
write_dx  in  DX_WIDTH  new X velocity
write_dy  in  DY_WIDTH  new Y velocity
write_mode  in  2  0 free, 1 wrap, 2 bounce, 3 = free
enable_update  in  NUM_SPRITES  per-sprite motion enable
bmp_we  in  1  write one bitmap row of wr_sel
bmp_row  in  ROW_W  row index
bmp_data  in  4*SPRITE_WIDTH  row pixels, 4-bit code each, MSB nibble = leftmost; 0 = transparent
collision_clear  in  1  clear all collision flags
sprite_x  out  NUM_SPRITES*w_x  packed X positions, sprite 0 in LSBs
sprite_y  out  NUM_SPRITES*w_y  packed Y positions
collision  out  NUM_SPRITES  sticky overlap flags
rgb_en  out  1  opaque sprite pixel present
rgb  out  `GAME_RGB_WIDTH  colour = low `GAME_RGB_WIDTH bits of the winning nibble
hit_id  out  SEL_W  index of the winning sprite

Behaviour:
- Reset (rst=0, async): all x, y, dx, dy = 0; mode = free; bitmaps all 0 (transparent); strobe counter = 0; rgb_en, rgb, hit_id, collision = 0.
- Strobe: the counter increments every clk. The strobe is the cycle in which the counter equals all-ones (then wraps to 0).
- Motion: on strobe, each sprite i with enable_update[i]=1 adds sign-extended dx/dy.
  - free: add modulo 2^w. Off-screen positions are simply not drawn.
  - wrap: result taken modulo screen_width / screen_height, covering both the negative and the overflow side.
  - bounce: if the result is <0, clamp to 0 and negate the velocity. If it is >screen-SPRITE dim, clamp to screen-SPRITE dim and negate the velocity. Axes are handled independently.
- Write priority: write_xy/write_dxy to sprite i override its strobe update in the same cycle. Writes take effect on the next cycle's outputs. Other sprites still update.
- The bitmap write and position/velocity writes may occur in the same cycle.
- sprite_x/sprite_y are direct register outputs.
- Hit test per sprite:
  - (pixel_x - x) mod 2^w_x < SPRITE_WIDTH and (pixel_y - y) mod 2^w_y < SPRITE_HEIGHT.
  - The pixel is only considered if pixel_x < screen_width and pixel_y < screen_height.
  - The addressed nibble must be nonzero.
- Priority: the lowest-index hitting sprite wins.
- Render latency: exactly 1 cycle. rgb_en/rgb/hit_id register the result for the pixel_x/pixel_y of the previous cycle. With no hit, rgb_en=0, rgb=0, hit_id=0.
- Collision: in any cycle where ≥2 sprites hit, set collision[i] for every hitting i (visible next cycle). collision_clear zeroes all flags. If a set and a clear coincide, the set wins for those bits.
- velocity most-negative value (e.g. -2 for DX_WIDTH=2) negates to itself; documented, not guarded.

Decomposition:
- Package game_sprite_multi_pkg: edge-mode enum (MODE_FREE, MODE_WRAP, MODE_BOUNCE), pixel code width constant (4), transparent code constant.
- One sub-module is natural: game_sprite_multi_motion (one sprite's x/y/dx/dy/mode registers, write muxing and edge arithmetic), instantiated NUM_SPRITES times with a generate loop.
- Bitmap storage, hit test, priority mux and collision logic stay in the top.

Test Plan:
- Reset: hold rst=0 5 cycles, release -> all sprite_x/y=0, rgb_en=0, collision=0; mid-run reset clears bitmaps and positions immediately.
- Bounce: strobe width 4, sprite 0 x=628, dx=+1, bounce, W=8 -> x goes 629..632, then stays 632 with dx=-1, next strobe 631.
- Wrap: sprite 1 x=0, dx=-1 (2'b11), wrap -> after strobe x=639; y=479, dy=+1 -> y=0.
- Render: sprite 2 at (100,50), row 0 = 32'h000cc000 -> pixel (103,50) gives rgb_en=1, rgb=3'b100, hit_id=2 one cycle later; pixel (100,50) gives rgb_en=0.
- Priority+collision: sprites 0 and 3 both opaque at (10,10) -> hit_id=0; collision=4'b1001 next cycle, stays after overlap ends; collision_clear -> 0; clear concurrent with new overlap -> bits stay set.
- Write precedence: write_xy to sprite 1 on the strobe cycle with enable_update=all ones -> sprite 1 takes written x/y unmodified while sprites 0,2,3 advance.
